ram_b_master: RTL and testbench

//  Initiator side of the RAM_B single-port block-RAM interface (clka/wea/addra/dina/douta).

---
 rtl/ram_b_pkg.sv | 22 ++
 rtl/ram_b_rd_pipe.sv | 30 +++
 rtl/ram_b_master.sv | 128 ++++++++++++
 tb/tb_ram_b_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_b_pkg.sv
// Shared constants and types for the RAM_B initiator.
package ram_b_pkg;

    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LEN_W  = 6;
    localparam int unsigned DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Tag that follows each issued read address through the RAM latency
    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/ram_b_rd_pipe.sv
// Read-tag delay line: aligns issued-read tags with douta from the RAM.
module ram_b_rd_pipe
    import ram_b_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_RD_LAT
) (
    input  logic    clka,
    input  logic    rsta,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clka) begin
        if (rsta) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/ram_b_master.sv
// Initiator for a single-port RAM_B: sequences burst reads/writes word by word
// and returns read data aligned to the configured RAM read latency.
module ram_b_master
    import ram_b_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta
);

    state_e            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    rd_tag_t           iss_tag;
    rd_tag_t           pipe_tag;

    // iss_tag is registered alongside addra, so the pipe only covers RAM latency
    ram_b_rd_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clka    (clka),
        .rsta    (rsta),
        .tag_in  (iss_tag),
        .tag_out (pipe_tag)
    );

    always_ff @(posedge clka) begin
        if (rsta) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            iss_tag   <= '0;
        end else begin
            wea      <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            iss_tag  <= '0;

            if (pipe_tag.valid) begin
                rd_valid <= 1'b1;
                rd_last  <= pipe_tag.last;
                rd_data  <= douta;
            end

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cur_addr  <= req_addr;
                        remaining <= req_len;
                        req_ready <= 1'b0;
                        if (req_we) begin
                            state    <= WR;
                            wr_ready <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                WR: begin
                    if (wr_valid) begin
                        wea      <= 1'b1;
                        addra    <= cur_addr;
                        dina     <= wr_data;
                        cur_addr <= cur_addr + ADDR_W'(1);
                        if (remaining == '0) begin
                            done      <= 1'b1;
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            remaining <= remaining - LEN_W'(1);
                        end
                    end
                end
                RD: begin
                    addra    <= cur_addr;
                    iss_tag  <= '{valid: 1'b1, last: (remaining == '0)};
                    cur_addr <= cur_addr + ADDR_W'(1);
                    if (remaining == '0) begin
                        state <= DRAIN;
                    end else begin
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    // Burst completes when the final tag leaves the pipe
                    if (pipe_tag.valid && pipe_tag.last) begin
                        done      <= 1'b1;
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_b_master.sv
// Directed bench: two initiators (RD_LAT=1 and RD_LAT=2) share one command stream,
// each driving its own behavioural RAM_B model.
module tb_ram_b_master;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_ev_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } rd_ev_t;

    logic        clka = 1'b0;
    logic        rsta;
    logic        req_valid;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [5:0]  req_len;
    logic        wr_valid;
    logic [31:0] wr_data;

    logic        req_ready [2];
    logic        wr_ready  [2];
    logic        rd_valid  [2];
    logic [31:0] rd_data   [2];
    logic        rd_last   [2];
    logic        done      [2];
    logic        wea       [2];
    logic [5:0]  addra     [2];
    logic [31:0] dina      [2];
    logic [31:0] douta     [2];

    int          cyc = 0;
    int          done_cnt [2] = '{0, 0};
    int          acc_cyc  [2] = '{0, 0};
    wr_ev_t      wr_q [2][$];
    rd_ev_t      rd_q [2][$];
    logic [31:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = g + 1;
        logic [31:0] mem [64];
        logic [31:0] q1;
        logic [31:0] q2;

        ram_b_master #(
            .ADDR_W (6),
            .DATA_W (32),
            .RD_LAT (LAT),
            .LEN_W  (6)
        ) u_dut (
            .clka      (clka),
            .rsta      (rsta),
            .req_valid (req_valid),
            .req_ready (req_ready[g]),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_len   (req_len),
            .wr_valid  (wr_valid),
            .wr_ready  (wr_ready[g]),
            .wr_data   (wr_data),
            .rd_valid  (rd_valid[g]),
            .rd_data   (rd_data[g]),
            .rd_last   (rd_last[g]),
            .done      (done[g]),
            .wea       (wea[g]),
            .addra     (addra[g]),
            .dina      (dina[g]),
            .douta     (douta[g])
        );

        // Read-first single-port RAM with optional output register
        always @(posedge clka) begin
            if (wea[g]) mem[addra[g]] <= dina[g];
            q1 <= mem[addra[g]];
            q2 <= q1;
        end
        assign douta[g] = (LAT == 1) ? q1 : q2;

        always @(negedge clka) begin
            if (wea[g]) wr_q[g].push_back('{addr: addra[g], data: dina[g], cyc: cyc});
            if (rd_valid[g]) rd_q[g].push_back('{data: rd_data[g], last: rd_last[g], cyc: cyc});
            if (done[g]) done_cnt[g] = done_cnt[g] + 1;
            if (req_valid && req_ready[g]) acc_cyc[g] = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [5:0] addr, input logic [5:0] len);
        int t = 0;
        while (!(req_ready[0] && req_ready[1]) && t < 200) begin
            step();
            t++;
        end
        check("cmd_ready", {62'd0, req_ready[0], req_ready[1]}, 64'd3);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        step();
        req_valid = 1'b0;
    endtask

    task automatic send_words(input int stall_at, input int stall_len);
        for (int i = 0; i < exp_q.size(); i++) begin
            int t = 0;
            if (i == stall_at) begin
                wr_valid = 1'b0;
                repeat (stall_len) step();
            end
            wr_valid = 1'b1;
            wr_data  = exp_q[i];
            while (!wr_ready[0] && t < 50) begin
                step();
                t++;
            end
            check("wr_ready", 64'(wr_ready[0]), 64'd1);
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int d1);
        int t = 0;
        while ((done_cnt[0] == d0 || done_cnt[1] == d1) && t < 200) begin
            step();
            t++;
        end
        check($sformatf("%s_done0", tag), 64'(done_cnt[0] - d0), 64'd1);
        check($sformatf("%s_done1", tag), 64'(done_cnt[1] - d1), 64'd1);
    endtask

    task automatic do_write(input string tag, input logic [5:0] addr, input int stall_at,
                            input int stall_len);
        int b  = wr_q[0].size();
        int d0 = done_cnt[0];
        int d1 = done_cnt[1];
        send_cmd(1'b1, addr, 6'(exp_q.size() - 1));
        send_words(stall_at, stall_len);
        wait_done(tag, d0, d1);
        check($sformatf("%s_wea_count", tag), 64'(wr_q[0].size() - b), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && b + i < wr_q[0].size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(wr_q[0][b+i].addr), 64'(6'(addr + i)));
            check($sformatf("%s_dina%0d", tag, i), 64'(wr_q[0][b+i].data), 64'(exp_q[i]));
        end
    endtask

    task automatic check_rd(input string tag, input int k, input int b);
        check($sformatf("%s_rd_count%0d", tag, k), 64'(rd_q[k].size() - b), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && b + i < rd_q[k].size(); i++) begin
            check($sformatf("%s_rd_data%0d_%0d", tag, k, i), 64'(rd_q[k][b+i].data), 64'(exp_q[i]));
            check($sformatf("%s_rd_last%0d_%0d", tag, k, i), 64'(rd_q[k][b+i].last),
                  64'(i == exp_q.size() - 1));
        end
        // accept edge -> addra edge -> RD_LAT RAM edges -> rd_data register edge
        if (rd_q[k].size() > b)
            check($sformatf("%s_latency%0d", tag, k), 64'(rd_q[k][b].cyc - acc_cyc[k]), 64'(k + 4));
    endtask

    task automatic do_read(input string tag, input logic [5:0] addr);
        int b0 = rd_q[0].size();
        int b1 = rd_q[1].size();
        int d0 = done_cnt[0];
        int d1 = done_cnt[1];
        send_cmd(1'b0, addr, 6'(exp_q.size() - 1));
        wait_done(tag, d0, d1);
        check_rd(tag, 0, b0);
        check_rd(tag, 1, b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int b0;
        int b1;
        int d0;
        int d1;

        rsta      = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        repeat (3) step();
        rsta = 1'b0;

        check("rst_req_ready0", 64'(req_ready[0]), 64'd1);
        check("rst_req_ready1", 64'(req_ready[1]), 64'd1);
        check("rst_wr_ready",   64'(wr_ready[0]),  64'd0);
        check("rst_rd_valid",   64'(rd_valid[0]),  64'd0);
        check("rst_done",       64'(done[0]),      64'd0);
        check("rst_wea",        64'(wea[0]),       64'd0);
        check("rst_addra",      64'(addra[0]),     64'd0);
        check("rst_dina",       64'(dina[0]),      64'd0);
        check("rst_rd_data",    64'(rd_data[0]),   64'd0);
        step();

        // Single word write then read back
        exp_q = '{32'h0000_0607};
        do_write("t1w", 6'd1, -1, 0);
        do_read("t1r", 6'd1);

        // Eight-word burst
        exp_q = {};
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i) * 32'h1111_1111);
        do_write("t2w", 6'd0, -1, 0);
        do_read("t2r", 6'd0);

        // Burst wrapping past the top address
        exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        do_write("t3w", 6'd62, -1, 0);
        do_read("t3r", 6'd62);

        // Three-cycle write stall between words 2 and 3
        exp_q = {};
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(i));
        b0 = wr_q[0].size();
        do_write("t4w", 6'd16, 3, 3);
        if (wr_q[0].size() >= b0 + 4)
            check("t4_stall_gap", 64'(wr_q[0][b0+3].cyc - wr_q[0][b0+2].cyc), 64'd4);
        do_read("t4r", 6'd16);

        // Reset two cycles into an eight-word read
        b0 = rd_q[0].size();
        b1 = rd_q[1].size();
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        send_cmd(1'b0, 6'd0, 6'd7);
        step();
        rsta = 1'b1;
        step();
        rsta = 1'b0;
        check("t5_req_ready0", 64'(req_ready[0]), 64'd1);
        check("t5_req_ready1", 64'(req_ready[1]), 64'd1);
        check("t5_rd_data",    64'(rd_data[0]),   64'd0);
        check("t5_wea",        64'(wea[0]),       64'd0);
        repeat (12) step();
        check("t5_no_rd0",   64'(rd_q[0].size() - b0), 64'd0);
        check("t5_no_rd1",   64'(rd_q[1].size() - b1), 64'd0);
        check("t5_no_done0", 64'(done_cnt[0] - d0),    64'd0);
        check("t5_no_done1", 64'(done_cnt[1] - d1),    64'd0);
        exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        do_read("t5r", 6'd62);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
